// File: rtl/lfsr_pkg.sv
// Shared types and the Galois step function for the LFSR stream scheduler.
// Bit order of every LFSR word is [0:LFSR_LEN-1].
package lfsr_pkg;

  localparam int LFSR_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM,
    DONE
  } state_t;

  function automatic logic [0:LFSR_LEN-1] lfsr_galois_next(
    input logic [0:LFSR_LEN-1] s,
    input logic [0:LFSR_LEN-1] taps
  );
    logic [0:LFSR_LEN-1] t;
    t = (taps & {LFSR_LEN{s[LFSR_LEN-1]}}) ^ s;
    return {t[LFSR_LEN-1], t[0:LFSR_LEN-2]};
  endfunction

endpackage

// File: rtl/lfsr_stream_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr.
// Produces both a one-hot grant and the winning index.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/lfsr_stream_scheduler.sv
// Time-shares one Galois LFSR step among NREQ saved contexts,
// streaming one granted burst at a time over valid/ready.
module lfsr_stream_scheduler
  import lfsr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LEN_W = 8,
  parameter logic [0:LFSR_LEN-1] TAPS = 16'b0110100000000000,
  parameter logic [0:LFSR_LEN-1] RST_SEED = 16'hACE1,
  localparam int LENGTH = LFSR_LEN,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       done,
  output logic [0:LENGTH-1]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDW-1:0]        out_id,
  output logic                  out_last,
  input  logic                  cfg_we,
  input  logic [IDW-1:0]        cfg_id,
  input  logic [0:LENGTH-1]     cfg_seed,
  output logic                  cfg_err
);

  state_t state, state_n;

  logic [0:LENGTH-1] ctx [NREQ];
  logic [0:LENGTH-1] work;
  logic [IDW-1:0]    id;
  logic [IDW-1:0]    id_nxt;
  logic [IDW-1:0]    ptr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len_sel;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gidx;
  logic              hs;
  logic              cfg_bad;
  logic              cfg_ok;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gidx)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) len_sel = len_sel | req_len[i*LEN_W +: LEN_W];
    end
  end

  assign id_nxt = (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
  assign hs     = (state == STREAM) && out_ready;

  // The id register is only meaningful once a burst has been granted.
  assign cfg_bad = cfg_we &&
                   ((cfg_seed == '0) ||
                    (int'(cfg_id) >= NREQ) ||
                    ((state != IDLE) && (cfg_id == id)));
  assign cfg_ok  = cfg_we && !cfg_bad;

  always_comb begin
    state_n   = state;
    done      = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) state_n = GRANT;
      end
      GRANT: begin
        if (rem == '0) begin
          done[id] = 1'b1;
          state_n  = IDLE;
        end else begin
          state_n = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = work;
        out_id    = id;
        out_last  = (rem == LEN_W'(1));
        if (hs && rem == LEN_W'(1)) state_n = DONE;
      end
      DONE: begin
        done[id] = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      work    <= '0;
      id      <= '0;
      ptr     <= '0;
      rem     <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NREQ; i++) ctx[i] <= RST_SEED;
    end else begin
      state   <= state_n;
      cfg_err <= cfg_bad;
      if (cfg_ok) ctx[cfg_id] <= cfg_seed;
      unique case (state)
        IDLE: begin
          if (|req) begin
            id   <= gidx;
            rem  <= len_sel;
            work <= ctx[gidx];
          end
        end
        GRANT: begin
          if (rem == '0) ptr <= id_nxt;
        end
        STREAM: begin
          if (hs) begin
            work <= lfsr_galois_next(work, TAPS);
            rem  <= rem - LEN_W'(1);
          end
        end
        DONE: begin
          ctx[id] <= work;
          ptr     <= id_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_stream_scheduler.sv
// Directed bench for lfsr_stream_scheduler: burst table plus
// hand sequences for arbitration, backpressure, config and reset.
module tb_lfsr_stream_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic [3:0]  done;
  logic [0:15] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_id;
  logic        out_last;
  logic        cfg_we;
  logic [1:0]  cfg_id;
  logic [0:15] cfg_seed;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit                rst_first;
    int                rid;
    int                len;
    logic [0:3][15:0]  w;
  } vec_t;

  vec_t tbl[7];

  logic [0:7][15:0] alt_d = {16'hACE1, 16'hE270, 16'hACE1, 16'hE270,
                             16'h7138, 16'h389C, 16'h7138, 16'h389C};
  int alt_id[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  always #5 clk = ~clk;

  lfsr_stream_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .done      (done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_last  (out_last),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_seed  (cfg_seed),
    .cfg_err   (cfg_err)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    req_len = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_id = '0;
    cfg_seed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("wait valid", 32'(out_valid), 1);
  endtask

  task automatic stream_check(input int r, input int n,
                              input logic [0:3][15:0] w, input int first,
                              input string nm, output int lat);
    int idx;
    int cyc;
    bit seen;
    idx = first;
    cyc = 0;
    seen = 0;
    lat = -1;
    out_ready = 1'b1;
    while (!seen && cyc < 60) begin
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        if (idx < n && idx < 4) begin
          check({nm, " data"}, 32'(out_data), 32'(w[idx]));
          check({nm, " id"}, 32'(out_id), r);
          check({nm, " last"}, 32'(out_last), 32'(idx == n - 1));
        end
        idx++;
      end
      if (done[r]) begin
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cyc++;
      end
    end
    check({nm, " words"}, idx, n);
    check({nm, " done"}, 32'(seen), 1);
  endtask

  task automatic run_burst(input int r, input int n,
                           input logic [0:3][15:0] w, input string nm);
    int lat;
    req[r] = 1'b1;
    req_len[r*8 +: 8] = 8'(n);
    stream_check(r, n, w, 0, nm, lat);
    if (n > 0) check({nm, " latency"}, lat, 2);
    req[r] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    int nd;
    int c;

    tbl[0] = '{1, 0, 3, {16'hACE1, 16'hE270, 16'h7138, 16'h0000}};
    tbl[1] = '{0, 0, 1, {16'h389C, 16'h0000, 16'h0000, 16'h0000}};
    tbl[2] = '{0, 0, 2, {16'h1C4E, 16'h0E27, 16'h0000, 16'h0000}};
    tbl[3] = '{0, 1, 4, {16'hACE1, 16'hE270, 16'h7138, 16'h389C}};
    tbl[4] = '{0, 2, 1, {16'hACE1, 16'h0000, 16'h0000, 16'h0000}};
    tbl[5] = '{0, 3, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    tbl[6] = '{0, 0, 1, {16'hB313, 16'h0000, 16'h0000, 16'h0000}};

    rst = 1'b0;
    req = '0;
    req_len = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_id = '0;
    cfg_seed = '0;
    #1;
    check("reset outs", {out_valid, out_last, cfg_err, done, out_id, out_data},
          '0);
    do_reset();
    check("post reset outs",
          {out_valid, out_last, cfg_err, done, out_id, out_data}, '0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst_first) do_reset();
      run_burst(tbl[i].rid, tbl[i].len, tbl[i].w, $sformatf("vec%0d", i));
    end

    // two requesters held together alternate grants
    do_reset();
    req_len[7:0] = 8'd2;
    req_len[15:8] = 8'd2;
    req[1:0] = 2'b11;
    n = 0;
    nd = 0;
    c = 0;
    while (nd < 4 && c < 100) begin
      if (out_valid) begin
        if (n < 8) begin
          check("alt data", 32'(out_data), 32'(alt_d[n]));
          check("alt id", 32'(out_id), alt_id[n]);
        end
        n++;
      end
      if (done != '0) nd++;
      if (nd < 4) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    req = '0;
    check("alt words", n, 8);
    check("alt dones", nd, 4);
    @(posedge clk);
    #1;

    // backpressure after the first word
    do_reset();
    req[2] = 1'b1;
    req_len[23:16] = 8'd4;
    wait_valid();
    check("bp w0", 32'(out_data), 32'hACE1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp w1", 32'(out_data), 32'hE270);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp hold valid", 32'(out_valid), 1);
      check("bp hold data", 32'(out_data), 32'hE270);
    end
    stream_check(2, 4, {16'hACE1, 16'hE270, 16'h7138, 16'h389C}, 1, "bp", lat);
    req[2] = 1'b0;
    @(posedge clk);
    #1;

    // config port
    do_reset();
    cfg_we = 1'b1;
    cfg_id = 2'd1;
    cfg_seed = 16'h0000;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg zero err", 32'(cfg_err), 1);
    @(posedge clk);
    #1;
    check("cfg err pulse", 32'(cfg_err), 0);
    run_burst(1, 1, {16'hACE1, 16'h0, 16'h0, 16'h0}, "cfg zero ctx");

    req[0] = 1'b1;
    req_len[7:0] = 8'd2;
    out_ready = 1'b0;
    wait_valid();
    cfg_we = 1'b1;
    cfg_id = 2'd0;
    cfg_seed = 16'h1234;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg active err", 32'(cfg_err), 1);
    stream_check(0, 2, {16'hACE1, 16'hE270, 16'h0, 16'h0}, 0, "cfg act", lat);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    run_burst(0, 1, {16'h7138, 16'h0, 16'h0, 16'h0}, "cfg act ctx");

    cfg_we = 1'b1;
    cfg_id = 2'd3;
    cfg_seed = 16'h0001;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg ok err", 32'(cfg_err), 0);
    run_burst(3, 1, {16'h0001, 16'h0, 16'h0, 16'h0}, "seed a");
    run_burst(3, 1, {16'hB400, 16'h0, 16'h0, 16'h0}, "seed b");

    cfg_we = 1'b1;
    cfg_id = 2'd2;
    cfg_seed = 16'h0001;
    run_burst(2, 1, {16'hACE1, 16'h0, 16'h0, 16'h0}, "grant cycle wr");

    // reset in the middle of a burst
    do_reset();
    req[1] = 1'b1;
    req_len[15:8] = 8'd3;
    wait_valid();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async rst valid", 32'(out_valid), 0);
    check("async rst data", 32'(out_data), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_burst(1, 1, {16'hACE1, 16'h0, 16'h0, 16'h0}, "after rst");
    run_burst(0, 0, {16'h0, 16'h0, 16'h0, 16'h0}, "len0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
